// File: rtl/re_mapper_multi_sym_if.sv
// Bus bundle for the multi-symbol RE mapper: configuration, DMRS memory
// read port, data stream handshake, grid write port and status.
interface re_mapper_multi_sym_if #(
  parameter int DATA_W = 18,
  parameter int DMRS_W = 9,
  parameter int SC_W   = 11,
  parameter int DA_W   = 12
);
  logic                     Start;
  logic [SC_W-1:0]          N_sc;
  logic [6:0]               N_rb;
  logic [3:0]               Sym_Start;
  logic [3:0]               Sym_End;
  logic [13:0]              Dmrs_Mask;
  logic                     Comb_Off;
  logic signed [DMRS_W-1:0] Dmrs_I;
  logic signed [DMRS_W-1:0] Dmrs_Q;
  logic signed [DATA_W-1:0] Data_I;
  logic signed [DATA_W-1:0] Data_Q;
  logic                     Data_Valid;
  logic                     Data_Ready;
  logic [DA_W-1:0]          DMRS_addr;
  logic                     Wr_en;
  logic [3:0]               Wr_sym;
  logic [SC_W-1:0]          Wr_sc;
  logic signed [DATA_W-1:0] RE_Real;
  logic signed [DATA_W-1:0] RE_Imj;
  logic                     Busy;
  logic                     Sym_Done;
  logic                     RE_Done;
  logic                     Cfg_Err;

  modport master (
    output Start, N_sc, N_rb, Sym_Start, Sym_End, Dmrs_Mask, Comb_Off,
    output Dmrs_I, Dmrs_Q, Data_I, Data_Q, Data_Valid,
    input  Data_Ready, DMRS_addr, Wr_en, Wr_sym, Wr_sc, RE_Real, RE_Imj,
    input  Busy, Sym_Done, RE_Done, Cfg_Err
  );

  modport slave (
    input  Start, N_sc, N_rb, Sym_Start, Sym_End, Dmrs_Mask, Comb_Off,
    input  Dmrs_I, Dmrs_Q, Data_I, Data_Q, Data_Valid,
    output Data_Ready, DMRS_addr, Wr_en, Wr_sym, Wr_sc, RE_Real, RE_Imj,
    output Busy, Sym_Done, RE_Done, Cfg_Err
  );
endinterface

// File: rtl/re_mapper_multi_sym.sv
// PUSCH RE mapper: writes one slot symbol by symbol into the grid, comb-2 DMRS
// on masked symbols and backpressured stream data elsewhere.
module re_mapper_multi_sym #(
  parameter int DATA_W     = 18,
  parameter int DMRS_W     = 9,
  parameter int DMRS_SHIFT = 0,
  parameter int N_GRID     = 1200,
  parameter int SC_W       = 11,
  parameter int DA_W       = 12
) (
  input  logic                  CLK_RE,
  input  logic                  RST_RE,
  re_mapper_multi_sym_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MAP_DMRS = 2'd1, MAP_DATA = 2'd2, DONE = 2'd3} state_t;

  state_t state_q, state_d;
  logic   start_q, start_d;

  logic [SC_W-1:0] n_sc_q, n_sc_d;
  logic [6:0]      n_rb_q, n_rb_d;
  logic [3:0]      sym_start_q, sym_start_d;
  logic [3:0]      sym_end_q, sym_end_d;
  logic [13:0]     mask_q, mask_d;
  logic            comb_q, comb_d;

  logic [3:0]      sym_q, sym_d;
  logic [SC_W-1:0] k_q, k_d;
  logic [DA_W-1:0] addr_q, addr_d;

  logic                     wr_en_q, wr_en_d;
  logic [3:0]               wr_sym_q, wr_sym_d;
  logic [SC_W-1:0]          wr_sc_q, wr_sc_d;
  logic signed [DATA_W-1:0] re_real_q, re_real_d;
  logic signed [DATA_W-1:0] re_imj_q, re_imj_d;
  logic                     busy_q, busy_d;
  logic                     sym_done_q, sym_done_d;
  logic                     re_done_q, re_done_d;
  logic                     cfg_err_q, cfg_err_d;

  logic [SC_W:0]            rb12, span;
  logic                     cfg_bad, last_k, adv;
  logic [3:0]               sym_nxt;
  logic signed [DATA_W-1:0] dm_i, dm_q;

  // One bit of headroom keeps N_sc + 12*N_rb from wrapping past the grid check.
  always_comb begin
    rb12    = (SC_W+1)'(n_rb_q) * (SC_W+1)'(12);
    span    = {1'b0, n_sc_q} + rb12;
    cfg_bad = (n_rb_q == 7'd0) || (sym_start_q > sym_end_q) ||
              (sym_end_q > 4'd13) || (span > (SC_W+1)'(N_GRID));
    last_k  = ({1'b0, k_q} == (rb12 - (SC_W+1)'(1)));
    sym_nxt = sym_q + 4'd1;
    dm_i    = DATA_W'(bus.Dmrs_I) <<< DMRS_SHIFT;
    dm_q    = DATA_W'(bus.Dmrs_Q) <<< DMRS_SHIFT;
  end

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    n_sc_d      = n_sc_q;
    n_rb_d      = n_rb_q;
    sym_start_d = sym_start_q;
    sym_end_d   = sym_end_q;
    mask_d      = mask_q;
    comb_d      = comb_q;
    sym_d       = sym_q;
    k_d         = k_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_sym_d    = sym_q;
    wr_sc_d     = n_sc_q + k_q;
    re_real_d   = '0;
    re_imj_d    = '0;
    sym_done_d  = 1'b0;
    re_done_d   = 1'b0;
    cfg_err_d   = 1'b0;
    adv         = 1'b0;

    case (state_q)
      IDLE: begin
        // Configuration is latched on Start and judged one cycle later.
        if (start_q) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            sym_d   = sym_start_q;
            k_d     = '0;
            addr_d  = '0;
            state_d = mask_q[sym_start_q] ? MAP_DMRS : MAP_DATA;
          end
        end else if (bus.Start) begin
          start_d     = 1'b1;
          n_sc_d      = bus.N_sc;
          n_rb_d      = bus.N_rb;
          sym_start_d = bus.Sym_Start;
          sym_end_d   = bus.Sym_End;
          mask_d      = bus.Dmrs_Mask;
          comb_d      = bus.Comb_Off;
        end
      end
      MAP_DMRS: begin
        adv     = 1'b1;
        wr_en_d = 1'b1;
        if (k_q[0] == comb_q) begin
          re_real_d = dm_i;
          re_imj_d  = dm_q;
          addr_d    = addr_q + DA_W'(1);
        end
      end
      MAP_DATA: begin
        if (bus.Data_Valid) begin
          adv       = 1'b1;
          wr_en_d   = 1'b1;
          re_real_d = bus.Data_I;
          re_imj_d  = bus.Data_Q;
        end
      end
      DONE: begin
        re_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Symbol boundary is taken in the same cycle as the last write: no gap.
    if (adv) begin
      if (last_k) begin
        sym_done_d = 1'b1;
        k_d        = '0;
        if (sym_q == sym_end_q) begin
          state_d = DONE;
        end else begin
          sym_d   = sym_nxt;
          state_d = mask_q[sym_nxt] ? MAP_DMRS : MAP_DATA;
        end
      end else begin
        k_d = k_q + SC_W'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_RE) begin
    if (!RST_RE) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      n_sc_q      <= '0;
      n_rb_q      <= '0;
      sym_start_q <= '0;
      sym_end_q   <= '0;
      mask_q      <= '0;
      comb_q      <= 1'b0;
      sym_q       <= '0;
      k_q         <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_sym_q    <= '0;
      wr_sc_q     <= '0;
      re_real_q   <= '0;
      re_imj_q    <= '0;
      busy_q      <= 1'b0;
      sym_done_q  <= 1'b0;
      re_done_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      n_sc_q      <= n_sc_d;
      n_rb_q      <= n_rb_d;
      sym_start_q <= sym_start_d;
      sym_end_q   <= sym_end_d;
      mask_q      <= mask_d;
      comb_q      <= comb_d;
      sym_q       <= sym_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_sym_q    <= wr_sym_d;
      wr_sc_q     <= wr_sc_d;
      re_real_q   <= re_real_d;
      re_imj_q    <= re_imj_d;
      busy_q      <= busy_d;
      sym_done_q  <= sym_done_d;
      re_done_q   <= re_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.Data_Ready = (state_q == MAP_DATA);
  assign bus.DMRS_addr  = addr_q;
  assign bus.Wr_en      = wr_en_q;
  assign bus.Wr_sym     = wr_sym_q;
  assign bus.Wr_sc      = wr_sc_q;
  assign bus.RE_Real    = re_real_q;
  assign bus.RE_Imj     = re_imj_q;
  assign bus.Busy       = busy_q;
  assign bus.Sym_Done   = sym_done_q;
  assign bus.RE_Done    = re_done_q;
  assign bus.Cfg_Err    = cfg_err_q;

endmodule

// File: tb/tb_re_mapper_multi_sym.sv
// Directed bench for re_mapper_multi_sym (DMRS_SHIFT=2): DMRS/data symbols,
// backpressure, config errors, mid-slot reset, sign extension and busy Start.
module tb_re_mapper_multi_sym;
  localparam int DATA_W = 18;
  localparam int DMRS_W = 9;
  localparam int SC_W   = 11;
  localparam int DA_W   = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   sign_mode = 1'b0;
  int   dv;
  int   addr;

  re_mapper_multi_sym_if #(.DATA_W(DATA_W), .DMRS_W(DMRS_W), .SC_W(SC_W), .DA_W(DA_W)) bus ();

  re_mapper_multi_sym #(
    .DATA_W(DATA_W), .DMRS_W(DMRS_W), .DMRS_SHIFT(2), .N_GRID(1200), .SC_W(SC_W), .DA_W(DA_W)
  ) dut (
    .CLK_RE (clk),
    .RST_RE (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // DMRS memory: I = addr+1, Q = -(addr+1); constant -256/255 in sign mode.
  always_comb begin
    dv = int'(bus.DMRS_addr) + 1;
    if (sign_mode) begin
      bus.Dmrs_I = -9'sd256;
      bus.Dmrs_Q = 9'sd255;
    end else begin
      bus.Dmrs_I = DMRS_W'(dv);
      bus.Dmrs_Q = DMRS_W'(-dv);
    end
  end

  function automatic int e_i(int a);
    return sign_mode ? -1024 : (a + 1) * 4;
  endfunction

  function automatic int e_q(int a);
    return sign_mode ? 1020 : -(a + 1) * 4;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives Start with a config; returns at the negedge after the decision edge.
  task automatic start_cfg(input int nsc, input int nrb, input int ss, input int se,
                           input int mask, input bit comb);
    bus.Start     = 1'b1;
    bus.N_sc      = SC_W'(nsc);
    bus.N_rb      = 7'(nrb);
    bus.Sym_Start = 4'(ss);
    bus.Sym_End   = 4'(se);
    bus.Dmrs_Mask = 14'(mask);
    bus.Comb_Off  = comb;
    @(negedge clk);
    bus.Start = 1'b0;
    chk("pending_busy", bus.Busy, 0);
    @(negedge clk);
  endtask

  task automatic run_sym(input int s, input int nsc, input int nrb, input bit dm, input bit comb,
                         input int nk, input bit fin, input int pulse_at, inout int a);
    int  last;
    int  ei, eq, pay;
    bit  hit;
    last = 12 * nrb - 1;
    for (int k = 0; k < nk; k++) begin
      hit = dm && ((k % 2) == int'(comb));
      pay = 1000 + s * 64 + k;
      ei  = dm ? (hit ? e_i(a) : 0) : pay;
      eq  = dm ? (hit ? e_q(a) : 0) : -pay;
      bus.Data_Valid = 1'b1;
      bus.Data_I     = DATA_W'(pay);
      bus.Data_Q     = DATA_W'(-pay);
      chk("data_ready", bus.Data_Ready, !dm);
      if (hit) chk("dmrs_addr", bus.DMRS_addr, a);
      if (k == pulse_at) begin
        bus.Start = 1'b1; bus.N_sc = '0; bus.N_rb = 7'd5;
        bus.Sym_Start = 4'd0; bus.Sym_End = 4'd13; bus.Dmrs_Mask = '0;
      end
      @(negedge clk);
      bus.Start = 1'b0;
      chk("wr_en", bus.Wr_en, 1);
      chk("wr_sym", bus.Wr_sym, s);
      chk("wr_sc", bus.Wr_sc, nsc + k);
      chk("re_real", bus.RE_Real, ei);
      chk("re_imj", bus.RE_Imj, eq);
      chk("sym_done", bus.Sym_Done, k == last);
      if (hit) a++;
    end
    if (fin) begin
      @(negedge clk);
      chk("re_done", bus.RE_Done, 1);
      chk("busy_end", bus.Busy, 0);
      chk("wr_en_end", bus.Wr_en, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Start = 1'b0; bus.N_sc = '0; bus.N_rb = '0; bus.Sym_Start = '0; bus.Sym_End = '0;
    bus.Dmrs_Mask = '0; bus.Comb_Off = 1'b0; bus.Data_I = '0; bus.Data_Q = '0; bus.Data_Valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", bus.Wr_en, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_ready", bus.Data_Ready, 0);
    chk("rst_addr", bus.DMRS_addr, 0);
    chk("rst_re_real", bus.RE_Real, 0);
    chk("rst_cfg_err", bus.Cfg_Err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single DMRS symbol, comb 0: even k carry (addr+1)*4.
    start_cfg(0, 1, 2, 2, 1 << 2, 1'b0);
    chk("t1_busy", bus.Busy, 1);
    chk("t1_no_wr", bus.Wr_en, 0);
    addr = 0;
    run_sym(2, 0, 1, 1'b1, 1'b0, 12, 1'b1, -1, addr);
    chk("t1_final_addr", bus.DMRS_addr, 6);

    // Data symbol with Data_Valid alternating; one beat past the end offered.
    start_cfg(24, 2, 3, 3, 0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      chk("t2_ready", bus.Data_Ready, 1);
      bus.Data_Valid = 1'b1;
      bus.Data_I = DATA_W'(200 + i);
      bus.Data_Q = DATA_W'(-(200 + i));
      @(negedge clk);
      chk("t2_wr_en", bus.Wr_en, 1);
      chk("t2_wr_sc", bus.Wr_sc, 24 + i);
      chk("t2_re_real", bus.RE_Real, 200 + i);
      chk("t2_re_imj", bus.RE_Imj, -(200 + i));
      chk("t2_sym_done", bus.Sym_Done, i == 23);
      chk("t2_ready_after", bus.Data_Ready, i != 23);
      bus.Data_Valid = (i == 23);
      @(negedge clk);
      chk("t2_idle_wr", bus.Wr_en, 0);
      if (i == 23) chk("t2_re_done", bus.RE_Done, 1);
    end
    bus.Data_Valid = 1'b0;
    @(negedge clk);
    chk("t2_ready_end", bus.Data_Ready, 0);

    // Full 14-symbol slot, DMRS on symbols 2 and 11, comb 1.
    start_cfg(0, 1, 0, 13, (1 << 2) | (1 << 11), 1'b1);
    addr = 0;
    for (int s = 0; s < 14; s++)
      run_sym(s, 0, 1, (s == 2) || (s == 11), 1'b1, 12, s == 13, -1, addr);
    chk("t3_addr_total", bus.DMRS_addr, 12);

    // Illegal configurations.
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       start_cfg(1190, 1, 0, 0, 0, 1'b0);
        1:       start_cfg(0, 1, 5, 4, 0, 1'b0);
        2:       start_cfg(0, 0, 0, 0, 0, 1'b0);
        default: start_cfg(0, 1, 0, 14, 0, 1'b0);
      endcase
      chk("t4_cfg_err", bus.Cfg_Err, 1);
      chk("t4_busy", bus.Busy, 0);
      chk("t4_wr_en", bus.Wr_en, 0);
      @(negedge clk);
      chk("t4_cfg_err_pulse", bus.Cfg_Err, 0);
      chk("t4_busy_after", bus.Busy, 0);
      chk("t4_ready", bus.Data_Ready, 0);
    end

    // Edge-of-grid slot, reset at k=5 of the data symbol, then a fresh slot.
    start_cfg(1188, 1, 12, 13, 1 << 12, 1'b0);
    addr = 0;
    run_sym(12, 1188, 1, 1'b1, 1'b0, 12, 1'b0, -1, addr);
    run_sym(13, 1188, 1, 1'b0, 1'b0, 5, 1'b0, -1, addr);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_wr_en", bus.Wr_en, 0);
    chk("t5_busy", bus.Busy, 0);
    chk("t5_ready", bus.Data_Ready, 0);
    chk("t5_addr", bus.DMRS_addr, 0);
    chk("t5_wr_sc", bus.Wr_sc, 0);
    chk("t5_re_real", bus.RE_Real, 0);
    chk("t5_sym_done", bus.Sym_Done, 0);
    @(negedge clk);
    chk("t5_idle_wr", bus.Wr_en, 0);
    chk("t5_idle_re_done", bus.RE_Done, 0);
    start_cfg(1188, 1, 12, 13, 1 << 13, 1'b0);
    addr = 0;
    run_sym(12, 1188, 1, 1'b0, 1'b0, 12, 1'b0, -1, addr);
    run_sym(13, 1188, 1, 1'b1, 1'b0, 12, 1'b1, -1, addr);

    // Negative DMRS sample through the shift; Start pulsed mid-slot is ignored.
    sign_mode = 1'b1;
    bus.Data_Valid = 1'b0;
    start_cfg(100, 1, 4, 4, 1 << 4, 1'b0);
    addr = 0;
    run_sym(4, 100, 1, 1'b1, 1'b0, 12, 1'b1, 3, addr);
    @(negedge clk);
    chk("t6_busy_idle", bus.Busy, 0);
    chk("t6_no_cfg_err", bus.Cfg_Err, 0);
    chk("t6_no_wr", bus.Wr_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
